// File: rtl/axi_master_burst.sv
// AXI4 burst initiator: one INCR read or write burst per local command, with
// local write/read beat streams and a one-cycle done pulse carrying the response.
module axi_master_burst #(
   parameter int DATA_WIDTH    = 32,
   parameter int STROBE_WIDTH  = DATA_WIDTH / 8,
   parameter int ADDRESS_WIDTH = 8
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   // command port
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic                     cmd_write,
   input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
   input  logic [7:0]               cmd_len,
   input  logic [2:0]               cmd_size,
   // local streams
   input  logic [DATA_WIDTH-1:0]    wr_data,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   output logic [DATA_WIDTH-1:0]    rd_data,
   output logic                     rd_last,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic                     done,
   output logic [1:0]               done_resp,
   // AXI write address / data / response
   output logic [ADDRESS_WIDTH-1:0] awaddr,
   output logic [7:0]               awlen,
   output logic [2:0]               awsize,
   output logic [1:0]               awburst,
   output logic                     awvalid,
   input  logic                     awready,
   output logic [DATA_WIDTH-1:0]    wdata,
   output logic [STROBE_WIDTH-1:0]  wstrb,
   output logic                     wlast,
   output logic                     wvalid,
   input  logic                     wready,
   input  logic [1:0]               bresp,
   input  logic                     bvalid,
   output logic                     bready,
   // AXI read address / data
   output logic [ADDRESS_WIDTH-1:0] araddr,
   output logic [7:0]               arlen,
   output logic [2:0]               arsize,
   output logic [1:0]               arburst,
   output logic                     arvalid,
   input  logic                     arready,
   input  logic [DATA_WIDTH-1:0]    rdata,
   input  logic [1:0]               rresp,
   input  logic                     rlast,
   input  logic                     rvalid,
   output logic                     rready
);

   localparam logic [2:0] MAX_SIZE = 3'($clog2(STROBE_WIDTH));

   typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP} state_t;

   state_t                   state, state_nxt;
   logic [ADDRESS_WIDTH-1:0] addr_q, size_mask, aligned_addr, beat_addr;
   logic [7:0]               len_q, beat_cnt;
   logic [2:0]               size_q, size_clamped;
   logic [1:0]               resp_max, resp_now;
   logic                     rlast_err, rlast_err_now;
   logic                     last_beat, cmd_fire, r_fire, w_fire, b_fire;
   int                       strb_lane, strb_bytes, strb_end;

   assign size_clamped  = (cmd_size > MAX_SIZE) ? MAX_SIZE : cmd_size;
   assign last_beat     = (beat_cnt == len_q);
   assign cmd_fire      = (state == IDLE)    && cmd_valid;
   assign r_fire        = (state == RD_DATA) && rvalid && rd_ready;
   assign w_fire        = (state == WR_DATA) && wr_valid && wready;
   assign b_fire        = (state == WR_RESP) && bvalid;
   assign resp_now      = (rresp > resp_max) ? rresp : resp_max;
   assign rlast_err_now = rlast_err | (rlast != last_beat);

   // Beat 0 keeps the caller's address; later beats step from the size-aligned base.
   assign size_mask    = (ADDRESS_WIDTH'(1) << size_q) - ADDRESS_WIDTH'(1);
   assign aligned_addr = addr_q & ~size_mask;
   assign beat_addr    = (beat_cnt == 8'd0) ? addr_q
                       : aligned_addr + (ADDRESS_WIDTH'(beat_cnt) << size_q);

   assign awaddr  = addr_q;
   assign awlen   = len_q;
   assign awsize  = size_q;
   assign awburst = 2'b01;
   assign araddr  = addr_q;
   assign arlen   = len_q;
   assign arsize  = size_q;
   assign arburst = 2'b01;
   assign wdata   = wr_data;
   assign wlast   = (state == WR_DATA) && last_beat;
   assign rd_data = rdata;
   assign rd_last = (state == RD_DATA) && last_beat;

   always_comb begin
      strb_bytes = 1 << size_q;
      strb_lane  = int'(beat_addr) % STROBE_WIDTH;
      strb_end   = strb_lane - (strb_lane % strb_bytes) + strb_bytes;
      for (int i = 0; i < STROBE_WIDTH; i++)
         wstrb[i] = (i >= strb_lane) && (i < strb_end);
   end

   always_comb begin
      // NOTE: every output gets a default before the case so no path infers a latch.
      state_nxt = state;
      cmd_ready = 1'b0;
      arvalid   = 1'b0;
      awvalid   = 1'b0;
      rready    = 1'b0;
      rd_valid  = 1'b0;
      wvalid    = 1'b0;
      wr_ready  = 1'b0;
      bready    = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_nxt = cmd_write ? WR_ADDR : RD_ADDR;
         end
         RD_ADDR: begin
            arvalid = 1'b1;
            if (arready) state_nxt = RD_DATA;
         end
         RD_DATA: begin
            rready   = rd_ready;
            rd_valid = rvalid;
            if (r_fire && last_beat) state_nxt = IDLE;
         end
         WR_ADDR: begin
            awvalid = 1'b1;
            if (awready) state_nxt = WR_DATA;
         end
         WR_DATA: begin
            wvalid   = wr_valid;
            wr_ready = wready;
            if (w_fire && last_beat) state_nxt = WR_RESP;
         end
         WR_RESP: begin
            bready = 1'b1;
            if (bvalid) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state     <= IDLE;
         addr_q    <= '0;
         len_q     <= '0;
         size_q    <= '0;
         beat_cnt  <= '0;
         resp_max  <= '0;
         rlast_err <= 1'b0;
         done      <= 1'b0;
         done_resp <= '0;
      end else begin
         state     <= state_nxt;
         done      <= 1'b0;
         done_resp <= '0;
         if (cmd_fire) begin
            addr_q    <= cmd_addr;
            len_q     <= cmd_len;
            size_q    <= size_clamped;
            beat_cnt  <= '0;
            resp_max  <= '0;
            rlast_err <= 1'b0;
         end
         if (r_fire) begin
            beat_cnt  <= beat_cnt + 8'd1;
            resp_max  <= resp_now;
            rlast_err <= rlast_err_now;
            if (last_beat) begin
               done      <= 1'b1;
               done_resp <= rlast_err_now ? 2'b10 : resp_now;
            end
         end
         if (w_fire) beat_cnt <= beat_cnt + 8'd1;
         if (b_fire) begin
            done      <= 1'b1;
            done_resp <= bresp;
         end
      end
   end

endmodule

// File: tb/tb_axi_master_burst.sv
// Directed bench for axi_master_burst: the bench plays the AXI slave and the
// local streams, with expected beats queued as stimulus is driven.
module tb_axi_master_burst;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [7:0]  cmd_addr, cmd_len;
   logic [2:0]  cmd_size;
   logic [31:0] wr_data, rd_data;
   logic        wr_valid, wr_ready, rd_last, rd_valid, rd_ready, done;
   logic [1:0]  done_resp;
   logic [7:0]  awaddr, awlen, araddr, arlen;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst, bresp, rresp;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic        arvalid, arready, rlast, rvalid, rready;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] data;
      logic        last;
      logic [7:0]  addr;
   } rd_exp_t;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  strb;
      logic        last;
      logic [7:0]  addr;
   } wr_exp_t;

   rd_exp_t rq[$];
   wr_exp_t wq[$];

   axi_master_burst dut (
      .aclk(aclk), .aresetn(aresetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .done(done), .done_resp(done_resp),
      .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   always #5 aclk = ~aclk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic slave_idle();
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
   endtask

   task automatic start_cmd(input logic wr, input logic [7:0] a, input logic [7:0] l,
                            input logic [2:0] s);
      @(negedge aclk);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_size = s;
      #1 check("cmd_ready_idle", cmd_ready, 1'b1);
      @(negedge aclk);
      cmd_valid = 1'b0;
      #1 check("cmd_ready_busy", cmd_ready, 1'b0);
   endtask

   // Read burst: bench is the R-channel slave; beats are data_base+n.
   task automatic read_burst(input logic [7:0] a, input logic [7:0] l, input logic [2:0] s,
                             input logic [2:0] exp_size, input int ar_delay,
                             input logic toggle, input int err_beat, input int bad_rlast_beat,
                             input logic [31:0] data_base, input logic [1:0] exp_resp);
      int n = 0, pushed = 0, guard = 0;
      int bytes = 1 << exp_size;
      logic [7:0] ea;
      rd_exp_t item;
      start_cmd(1'b0, a, l, s);
      check("arvalid_rise", arvalid, 1'b1);
      check("araddr", araddr, a);
      check("arlen", arlen, l);
      check("arsize", arsize, exp_size);
      check("arburst", arburst, 2'b01);
      for (int i = 0; i < ar_delay; i++) begin
         @(negedge aclk);
         #1 check("arvalid_hold", {arvalid, araddr}, {1'b1, a});
      end
      arready = 1'b1;
      @(negedge aclk);
      arready = 1'b0;
      while (n <= int'(l) && guard < 2000) begin
         @(negedge aclk);
         guard++;
         if (pushed == n) begin
            ea = (n == 0) ? a : (a & ~8'(bytes - 1)) + 8'(n * bytes);
            rq.push_back('{data: data_base + 32'(n), last: (n == int'(l)), addr: ea});
            pushed++;
         end
         rvalid = 1'b1;
         rdata  = data_base + 32'(n);
         rresp  = (n == err_beat) ? 2'b10 : 2'b00;
         rlast  = (n == int'(l)) || (n == bad_rlast_beat);
         rd_ready = toggle ? guard[0] : 1'b1;
         #1;
         check("rd_valid", rd_valid, 1'b1);
         check("rready", rready, rd_ready);
         if (rd_ready) begin
            item = rq.pop_front();
            check("rd_data", rd_data, item.data);
            check("rd_last", rd_last, item.last);
            check("r_beat_addr", dut.beat_addr, item.addr);
            n++;
         end
      end
      check("r_beats", n, int'(l) + 1);
      @(negedge aclk);
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rd_ready = 1'b0;
      #1;
      check("r_done", done, 1'b1);
      check("r_done_resp", done_resp, exp_resp);
      check("r_cmd_ready_done", cmd_ready, 1'b1);
      check("r_queue_empty", rq.size(), 0);
      @(negedge aclk);
      #1 check("r_done_pulse", done, 1'b0);
   endtask

   // Write burst: expected beats must already be queued in wq.
   task automatic write_burst(input logic [7:0] a, input logic [7:0] l, input logic [2:0] s,
                              input int aw_delay, input logic [1:0] b_in);
      wr_exp_t item;
      start_cmd(1'b1, a, l, s);
      wr_valid = 1'b1; wr_data = 32'hDEAD_BEEF; wready = 1'b1;
      #1;
      check("awvalid_rise", awvalid, 1'b1);
      check("awaddr", awaddr, a);
      check("awlen", awlen, l);
      check("awsize", awsize, s);
      check("awburst", awburst, 2'b01);
      check("w_before_aw", {wvalid, wr_ready}, 2'b00);
      for (int i = 0; i < aw_delay; i++) begin
         @(negedge aclk);
         #1 check("w_before_aw_wait", {awvalid, wvalid}, 2'b10);
      end
      awready = 1'b1;
      for (int n = 0; n <= int'(l); n++) begin
         @(negedge aclk);
         awready = 1'b0;
         check("wq_has_beat", wq.size() > 0, 1'b1);
         item = wq.pop_front();
         wr_data = item.data; wr_valid = 1'b1; wready = 1'b1;
         #1;
         check("wvalid", wvalid, 1'b1);
         check("wr_ready", wr_ready, 1'b1);
         check("wdata", wdata, item.data);
         check("wstrb", wstrb, item.strb);
         check("wlast", wlast, item.last);
         check("w_beat_addr", dut.beat_addr, item.addr);
      end
      @(negedge aclk);
      wr_valid = 1'b0; wready = 1'b0;
      #1 check("bready", bready, 1'b1);
      bvalid = 1'b1; bresp = b_in;
      @(negedge aclk);
      bvalid = 1'b0; bresp = 2'b00;
      #1;
      check("w_done", done, 1'b1);
      check("w_done_resp", done_resp, b_in);
      check("w_cmd_ready_done", cmd_ready, 1'b1);
      @(negedge aclk);
      #1 check("w_done_pulse", done, 1'b0);
   endtask

   initial begin
      aresetn = 1'b0;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = '0;
      wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
      slave_idle();
      #1;
      check("rst_cmd_ready", cmd_ready, 1'b1);
      check("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
      check("rst_local", {wr_ready, rd_valid, done, done_resp}, 5'b0);
      check("rst_addr", {awaddr, araddr}, 16'h0);
      repeat (2) @(negedge aclk);
      aresetn = 1'b1;

      // Aligned read, AR accepted after 2 cycles.
      read_burst(8'h10, 8'd3, 3'd2, 3'd2, 2, 1'b0, -1, -1, 32'hA0, 2'b00);

      // Aligned full-width write.
      wq.push_back('{data: 32'h1111_1111, strb: 4'hF, last: 1'b0, addr: 8'h20});
      wq.push_back('{data: 32'h2222_2222, strb: 4'hF, last: 1'b1, addr: 8'h24});
      write_burst(8'h20, 8'd1, 3'd2, 1, 2'b00);

      // Unaligned narrow write.
      wq.push_back('{data: 32'hAAAA_0001, strb: 4'b1000, last: 1'b0, addr: 8'h03});
      wq.push_back('{data: 32'hAAAA_0002, strb: 4'b0011, last: 1'b0, addr: 8'h04});
      wq.push_back('{data: 32'hAAAA_0003, strb: 4'b1100, last: 1'b1, addr: 8'h06});
      write_burst(8'h03, 8'd2, 3'd1, 0, 2'b01);

      // Backpressured read, SLVERR on beat 4, oversized cmd_size clamps to 2.
      read_burst(8'h40, 8'd7, 3'd3, 3'd2, 0, 1'b1, 4, -1, 32'hB0, 2'b10);

      // Early rlast on beat 1: burst still runs 4 beats, reported as SLVERR.
      read_burst(8'h80, 8'd3, 3'd2, 3'd2, 1, 1'b0, -1, 1, 32'hC0, 2'b10);

      // Reset in the middle of a write burst, after beat 0.
      start_cmd(1'b1, 8'h30, 8'd3, 3'd2);
      awready = 1'b1;
      @(negedge aclk);
      awready = 1'b0; wr_valid = 1'b1; wr_data = 32'h3333_3333; wready = 1'b1;
      #1 check("mid_w_beat0", wvalid, 1'b1);
      @(negedge aclk);
      aresetn = 1'b0;
      slave_idle();
      wr_valid = 1'b0;
      #1;
      check("mid_rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
      check("mid_rst_cmd_ready", cmd_ready, 1'b1);
      check("mid_rst_done", done, 1'b0);
      @(negedge aclk);
      aresetn = 1'b1;

      // Read wrapping through the top of the address space.
      read_burst(8'hFC, 8'd1, 3'd2, 3'd2, 0, 1'b0, -1, -1, 32'hD0, 2'b00);

      repeat (2) @(negedge aclk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axi_master_burst.md
# axi_master_burst

AXI4 burst initiator that drives the AR/R and AW/W/B channels of a single AXI slave, such as the team's AXI slave RAM. A local command port requests one INCR read or write burst at a time. Write beats are pulled from a local stream and read beats are pushed to a local stream. A one-cycle done pulse reports the burst response.

## Interface
Parameters:
- DATA_WIDTH, 32, data bus width in bits (multiple of 8)
- STROBE_WIDTH, DATA_WIDTH/8, byte lanes
- ADDRESS_WIDTH, 8, address width in bits

Ports:
- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  asynchronous, active-low reset
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDRESS_WIDTH  start byte address
- cmd_len  in  8  beats minus one (AXI encoding)
- cmd_size  in  3  log2 bytes per beat
- wr_data  in  DATA_WIDTH  write beat data
- wr_valid / wr_ready  in / out  1  write stream handshake
- rd_data  out  DATA_WIDTH  read beat data
- rd_last  out  1  final read beat
- rd_valid / rd_ready  out / in  1  read stream handshake
- done  out  1  one-cycle completion pulse
- done_resp  out  2  burst response, valid only while done = 1
- AXI master ports, same names and widths as the slave: awaddr, awlen, awsize, awburst, awvalid, awready; wdata, wstrb, wlast, wvalid, wready; bresp, bvalid, bready; araddr, arlen, arsize, arburst, arvalid, arready; rdata, rresp, rlast, rvalid, rready.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP.
- cmd_ready = 1 only in IDLE.
- Accepting a command latches addr, len, size and direction, then moves to RD_ADDR or WR_ADDR.
- Size clamp: cmd_size greater than log2(STROBE_WIDTH) is clamped to log2(STROBE_WIDTH).
- Fixed AXI fields: awburst = arburst = 2'b01 (INCR); awlen/arlen = latched len; awsize/arsize = clamped size.
- Address channels:
  - RD_ADDR drives arvalid = 1 and araddr = latched addr, held stable until arready; the handshake moves to RD_DATA.
  - WR_ADDR does the same on the AW channel; the handshake moves to WR_DATA.
- RD_DATA:
  - Combinational connections: rready = rd_ready, rd_valid = rvalid, rd_data = rdata, rd_last = (beat_cnt == len).
  - Each rvalid&&rready increments beat_cnt.
  - On the final beat, go to IDLE and pulse done.
- WR_DATA:
  - Combinational connections: wvalid = wr_valid, wr_ready = wready, wdata = wr_data, wlast = (beat_cnt == len).
  - Each wvalid&&wready increments beat_cnt.
  - After the final beat, go to WR_RESP.
- WR_RESP: bready = 1; on bvalid, pulse done with done_resp = bresp and return to IDLE.
- W data is never issued before the AW handshake completes.
- Beat addressing:
  - Beat address for beat 0 is addr. For beat n > 0 it is aligned_addr + n*2^size, where aligned_addr = addr with the low size bits cleared.
  - Arithmetic is modulo 2^ADDRESS_WIDTH; wrap is silent and the burst is never split.
- wstrb:
  - Lanes [lane, (aligned lane) + 2^size) are set, where lane = beat address mod STROBE_WIDTH and the aligned lane is lane with the low size bits cleared.
  - Beat 0 of an unaligned address therefore omits the leading lanes.
  - Full-width aligned beats give all ones.
- Read response:
  - done_resp = numerically largest rresp seen in the burst.
  - It is forced to 2'b10 if rlast disagrees with (beat_cnt == len) on any beat.
  - beat_cnt alone decides when the burst ends.

## Timing
- Reset values: all AXI valid/ready outputs 0; cmd_ready 1; wr_ready 0; rd_valid 0; done 0; done_resp 0; address outputs 0; state IDLE.
- Reset asserted mid-burst aborts immediately. No response is reported, and the slave must be reset alongside.
- Latency:
  - arvalid/awvalid rise the cycle after cmd handshake.
  - Read done pulses the cycle after the final R handshake.
  - Write done pulses the cycle after the B handshake.
  - cmd_ready returns in that same done cycle, so back-to-back commands incur 1 idle cycle.
- Valids, once asserted, stay asserted with stable payload until their handshake completes.
- beat_cnt is 8 bits; len = 255 gives 256 beats without overflow ambiguity, since comparison uses equality before increment.

## Test plan
- Read, addr 0x10, len 3, size 2, slave arready after 2 cycles, R beats 0xA0..0xA3 with rd_ready always 1 → araddr = 0x10, arlen = 3, arburst = 1; rd_data 0xA0..0xA3; rd_last on beat 3; done with done_resp = 0.
- Write, addr 0x20, len 1, size 2, data 0x11111111 then 0x22222222, bresp = 0 → wstrb = 4'hF both beats; wlast on beat 1 only; wvalid never before the AW handshake; done_resp = 0.
- Unaligned narrow write, addr 0x03, len 2, size 1 → beat addresses 0x03, 0x04, 0x06; wstrb = 4'b1000, 4'b0011, 4'b1100.
- Read backpressure, rd_ready toggles every cycle, len 7 → exactly 8 beats transferred with no duplicates; rresp 2'b10 on beat 4 gives done_resp = 2.
- Slave asserts rlast on beat 1 of a len-3 read → 4 beats still consumed; done_resp = 2'b10.
- aresetn pulsed low during WR_DATA after beat 0 → all valids 0 and cmd_ready 1 while in reset. Afterwards a new read to 0xFC, len 1, size 2 wraps its beat-1 address to 0x00.
